// File: rtl/dmem_bridge.sv
// Bridges the core's single-cycle M-stage data port onto a split address/data bus.
// Stalls the pipeline until the response arrives, and bounds each access with a timeout.
module dmem_bridge #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memreadM,
    input  logic        memwriteM,
    input  logic [31:0] aluoutM,
    input  logic [31:0] writedataM,
    input  logic [3:0]  selectM,
    output logic [31:0] readdataM,
    output logic        stall_mem,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [3:0]  data_wstrb,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic        bus_err
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [1:0]  dec_size;
    logic [1:0]  dec_off;
    logic        req;
    logic        timeout;
    logic        unused_addr_lsb;

    assign req             = memreadM | memwriteM;
    assign unused_addr_lsb = ^aluoutM[1:0];
    // Fires on the TIMEOUT_CYC-th cycle spent in ADDR+DATA.
    assign timeout = ({1'b0, cnt_q} + 17'd1) == 17'(TIMEOUT_CYC);

    always_comb begin
        dec_size = 2'd2;
        dec_off  = 2'd0;
        case (selectM)
            4'b0011: begin dec_size = 2'd1; dec_off = 2'd0; end
            4'b1100: begin dec_size = 2'd1; dec_off = 2'd2; end
            4'b0001: begin dec_size = 2'd0; dec_off = 2'd0; end
            4'b0010: begin dec_size = 2'd0; dec_off = 2'd1; end
            4'b0100: begin dec_size = 2'd0; dec_off = 2'd2; end
            4'b1000: begin dec_size = 2'd0; dec_off = 2'd3; end
            default: begin dec_size = 2'd2; dec_off = 2'd0; end
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wstrb_d = wstrb_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = ADDR;
                    cnt_d   = 16'd0;
                    wr_d    = memwriteM;
                    size_d  = dec_size;
                    addr_d  = {aluoutM[31:2], dec_off};
                    wstrb_d = memwriteM ? selectM : 4'b0000;
                    wdata_d = writedataM;
                end
            end
            ADDR: begin
                cnt_d = cnt_q + 16'd1;
                if (data_addr_ok && data_data_ok) begin
                    state_d = DONE;
                    if (!wr_q) rdata_d = data_rdata;
                end else if (timeout) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                    if (!wr_q) rdata_d = 32'd0;
                end else if (data_addr_ok) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                cnt_d = cnt_q + 16'd1;
                // A response landing on the timeout cycle still counts as success.
                if (data_data_ok) begin
                    state_d = DONE;
                    if (!wr_q) rdata_d = data_rdata;
                end else if (timeout) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                    if (!wr_q) rdata_d = 32'd0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 16'd0;
            wr_q    <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= 32'd0;
            wstrb_q <= 4'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wstrb_q <= wstrb_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign stall_mem  = ((state_q == IDLE) && req) || (state_q == ADDR) || (state_q == DATA);
    assign data_req   = (state_q == ADDR);
    assign data_wr    = wr_q;
    assign data_size  = size_q;
    assign data_addr  = addr_q;
    assign data_wstrb = wstrb_q;
    assign data_wdata = wdata_q;
    assign readdataM  = rdata_q;
    assign bus_err    = err_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge: a latency-configurable slave, a transaction-level
// model compared every cycle, and hand-computed checks for each scenario.
module tb_dmem_bridge;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        memreadM = 1'b0;
    logic        memwriteM = 1'b0;
    logic [31:0] aluoutM = 32'd0;
    logic [31:0] writedataM = 32'd0;
    logic [3:0]  selectM = 4'd0;
    logic [31:0] readdataM;
    logic        stall_mem;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok = 1'b0;
    logic        data_data_ok = 1'b0;
    logic [31:0] data_rdata = 32'd0;
    logic        bus_err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    dmem_bridge #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .memreadM(memreadM), .memwriteM(memwriteM), .aluoutM(aluoutM),
        .writedataM(writedataM), .selectM(selectM),
        .readdataM(readdataM), .stall_mem(stall_mem),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata), .bus_err(bus_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- slave ----------------
    int          a_lat = 0;
    int          d_lat = 0;
    bit          dead = 1'b0;
    logic [31:0] slave_rdata = 32'd0;
    int          req_wait = 0;
    int          dwait = 0;
    bit          pending = 1'b0;
    int          req_pulses = 0;
    logic        prev_req = 1'b0;
    logic [31:0] acc_addr = 32'd0;
    logic [31:0] acc_wdata = 32'd0;
    logic [1:0]  acc_size = 2'd0;
    logic [3:0]  acc_wstrb = 4'd0;
    logic        acc_wr = 1'b0;

    always @(negedge clk) begin
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata   = slave_rdata;
        if (data_req && !prev_req) req_pulses++;
        prev_req = data_req;
        if (pending) begin
            if (dwait >= d_lat) begin
                data_data_ok = 1'b1;
                pending = 1'b0;
            end else dwait++;
        end else if (data_req && !dead) begin
            if (req_wait >= a_lat) begin
                data_addr_ok = 1'b1;
                req_wait  = 0;
                acc_addr  = data_addr;
                acc_size  = data_size;
                acc_wstrb = data_wstrb;
                acc_wr    = data_wr;
                acc_wdata = data_wdata;
                if (d_lat == 0) data_data_ok = 1'b1;
                else begin
                    pending = 1'b1;
                    dwait = 1;
                end
            end else req_wait++;
        end
    end

    // ---------------- transaction model ----------------
    bit          m_active = 1'b0, m_taken = 1'b0, m_done = 1'b0, m_wr = 1'b0, m_err = 1'b0;
    int          m_elapsed = 0;
    logic [31:0] m_addr = 32'd0, m_wdata = 32'd0, m_rdata = 32'd0;
    logic [3:0]  m_strb = 4'd0;
    logic [1:0]  m_size = 2'd0;

    function automatic void decode(input logic [3:0] s, output logic [1:0] sz, output logic [1:0] off);
        sz = 2'd2;
        off = 2'd0;
        if (s == 4'b0011) sz = 2'd1;
        else if (s == 4'b1100) begin
            sz = 2'd1;
            off = 2'd2;
        end else if ($countones(s) == 1) begin
            sz = 2'd0;
            for (int i = 0; i < 4; i++) if (s[i]) off = 2'(i);
        end
    endfunction

    always @(posedge clk) begin
        logic [1:0] sz, off;
        if (!rst) begin
            m_active = 0; m_taken = 0; m_done = 0; m_wr = 0; m_err = 0;
            m_elapsed = 0; m_rdata = 32'd0;
        end else if (m_done) begin
            m_done = 0;
        end else if (m_active) begin
            m_elapsed++;
            if ((!m_taken && data_addr_ok && data_data_ok) || (m_taken && data_data_ok)) begin
                if (!m_wr) m_rdata = data_rdata;
                m_active = 0;
                m_done = 1;
            end else if (m_elapsed == TO) begin
                m_err = 1;
                if (!m_wr) m_rdata = 32'd0;
                m_active = 0;
                m_done = 1;
            end else if (!m_taken && data_addr_ok) begin
                m_taken = 1;
            end
        end else if (memreadM || memwriteM) begin
            decode(selectM, sz, off);
            m_active  = 1;
            m_taken   = 0;
            m_elapsed = 0;
            m_wr      = memwriteM;
            m_size    = sz;
            m_addr    = {aluoutM[31:2], off};
            m_strb    = memwriteM ? selectM : 4'b0000;
            m_wdata   = writedataM;
        end
    end

    always @(negedge clk) begin
        check("m_stall", 32'(stall_mem), 32'(m_active || (!m_done && (memreadM || memwriteM))));
        check("m_req", 32'(data_req), 32'(m_active && !m_taken));
        check("m_readdata", readdataM, m_rdata);
        check("m_bus_err", 32'(bus_err), 32'(m_err));
        if (m_active) begin
            check("m_wr", 32'(data_wr), 32'(m_wr));
            check("m_size", 32'(data_size), 32'(m_size));
            check("m_addr", data_addr, m_addr);
            check("m_wstrb", 32'(data_wstrb), 32'(m_strb));
            if (m_wr) check("m_wdata", data_wdata, m_wdata);
        end
    end

    // ---------------- directed stimulus ----------------
    // Entered at posedge+2 of the cycle the request is presented; returns at posedge+2
    // of the IDLE cycle after DONE with the request lines dropped.
    task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] sel,
                          output int stalls, output logic [31:0] rdo);
        memreadM = rd;
        memwriteM = wr;
        aluoutM = a;
        writedataM = wd;
        selectM = sel;
        stalls = 0;
        #2;
        for (int i = 0; i < 50; i++) begin
            if (!stall_mem) break;
            stalls++;
            @(posedge clk);
            #4;
        end
        check("access_bounded", 32'(stall_mem), 32'd0);
        rdo = readdataM;
        @(posedge clk);
        #2;
        memreadM = 1'b0;
        memwriteM = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          st;
        int          p0;
        logic [31:0] rd;

        repeat (2) @(posedge clk);
        #2;
        check("rst_readdata", readdataM, 32'd0);
        check("rst_bus_err", 32'(bus_err), 32'd0);
        check("rst_req", 32'(data_req), 32'd0);
        check("rst_stall", 32'(stall_mem), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #2;

        // 1: word load, addr_ok on first ADDR cycle, data_ok two cycles later
        a_lat = 0; d_lat = 2; slave_rdata = 32'hCAFEF00D;
        access(1'b1, 1'b0, 32'h100, 32'd0, 4'b1111, st, rd);
        check("t1_stalls", 32'(st), 32'd4);
        check("t1_rdata", rd, 32'hCAFEF00D);
        check("t1_size", 32'(acc_size), 32'd2);
        check("t1_addr", acc_addr, 32'h100);
        check("t1_wstrb", 32'(acc_wstrb), 32'd0);

        // 2: byte store, same-cycle addr_ok and data_ok
        a_lat = 0; d_lat = 0; slave_rdata = 32'h12345678;
        access(1'b0, 1'b1, 32'h203, 32'hAB000000, 4'b1000, st, rd);
        check("t2_stalls", 32'(st), 32'd2);
        check("t2_rdata_kept", rd, 32'hCAFEF00D);
        check("t2_addr", acc_addr, 32'h203);
        check("t2_size", 32'(acc_size), 32'd0);
        check("t2_wstrb", 32'(acc_wstrb), 32'b1000);
        check("t2_wr", 32'(acc_wr), 32'd1);
        check("t2_wdata", acc_wdata, 32'hAB000000);

        // 3: back-to-back loads, no re-issue from DONE
        p0 = req_pulses;
        slave_rdata = 32'h11111111;
        access(1'b1, 1'b0, 32'h300, 32'd0, 4'b1111, st, rd);
        check("t3a_rdata", rd, 32'h11111111);
        check("t3a_stalls", 32'(st), 32'd2);
        slave_rdata = 32'h22222222;
        access(1'b1, 1'b0, 32'h304, 32'd0, 4'b1111, st, rd);
        check("t3b_rdata", rd, 32'h22222222);
        repeat (3) @(posedge clk);
        #2;
        check("t3_req_pulses", 32'(req_pulses - p0), 32'd2);

        // 6: both requests high -> write wins, half-word upper lanes
        a_lat = 1; d_lat = 1; slave_rdata = 32'h33333333;
        access(1'b1, 1'b1, 32'h400, 32'h55660000, 4'b1100, st, rd);
        check("t6_wr", 32'(acc_wr), 32'd1);
        check("t6_size", 32'(acc_size), 32'd1);
        check("t6_addr", acc_addr, 32'h402);
        check("t6_wstrb", 32'(acc_wstrb), 32'b1100);
        check("t6_stalls", 32'(st), 32'd4);
        check("t6_rdata_kept", rd, 32'h22222222);

        // irregular select -> word at aligned address
        a_lat = 0; d_lat = 1; slave_rdata = 32'h0BADBEEF;
        access(1'b1, 1'b0, 32'h503, 32'd0, 4'b0101, st, rd);
        check("t7_addr", acc_addr, 32'h500);
        check("t7_size", 32'(acc_size), 32'd2);
        check("t7_stalls", 32'(st), 32'd3);
        check("t7_rdata", rd, 32'h0BADBEEF);

        // response on exactly the timeout cycle completes normally
        a_lat = TO - 1; d_lat = 0; slave_rdata = 32'h77777777;
        access(1'b1, 1'b0, 32'h700, 32'd0, 4'b1111, st, rd);
        check("tb_stalls", 32'(st), 32'(TO + 1));
        check("tb_rdata", rd, 32'h77777777);
        check("tb_no_err", 32'(bus_err), 32'd0);

        // 4: dead slave -> timeout
        dead = 1'b1; a_lat = 0;
        access(1'b1, 1'b0, 32'h800, 32'd0, 4'b1111, st, rd);
        check("t4_stalls", 32'(st), 32'(TO + 1));
        check("t4_rdata", rd, 32'd0);
        check("t4_bus_err", 32'(bus_err), 32'd1);
        dead = 1'b0; a_lat = 0; d_lat = 0; slave_rdata = 32'h99999999;
        access(1'b1, 1'b0, 32'h804, 32'd0, 4'b1111, st, rd);
        check("t4_next_rdata", rd, 32'h99999999);
        check("t4_next_stalls", 32'(st), 32'd2);
        check("t4_err_sticky", 32'(bus_err), 32'd1);

        // store timing out in DATA; the late data_ok lands while idle
        d_lat = 12;
        access(1'b0, 1'b1, 32'h808, 32'hFFFF0000, 4'b1100, st, rd);
        check("tw_stalls", 32'(st), 32'(TO + 1));
        check("tw_rdata_kept", rd, 32'h99999999);
        repeat (8) @(posedge clk);
        #2;
        check("tw_stray_rdata", readdataM, 32'h99999999);
        check("tw_stray_stall", 32'(stall_mem), 32'd0);

        // 5: reset during DATA, stray data_ok afterwards
        a_lat = 0; d_lat = 5; slave_rdata = 32'hDEADBEEF;
        memreadM = 1'b1; aluoutM = 32'h900; selectM = 4'b1111;
        repeat (3) @(posedge clk);
        #2;
        check("t5_in_data_stall", 32'(stall_mem), 32'd1);
        check("t5_in_data_req", 32'(data_req), 32'd0);
        rst = 1'b0;
        memreadM = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        check("t5_rst_readdata", readdataM, 32'd0);
        check("t5_rst_req", 32'(data_req), 32'd0);
        check("t5_rst_stall", 32'(stall_mem), 32'd0);
        check("t5_rst_err", 32'(bus_err), 32'd0);
        p0 = req_pulses;
        repeat (6) @(posedge clk);
        #2;
        check("t5_stray_readdata", readdataM, 32'd0);
        check("t5_stray_req", 32'(req_pulses - p0), 32'd0);
        a_lat = 0; d_lat = 0; slave_rdata = 32'h0F0F1234;
        access(1'b1, 1'b0, 32'hA02, 32'd0, 4'b0100, st, rd);
        check("t5_after_rdata", rd, 32'h0F0F1234);
        check("t5_after_addr", acc_addr, 32'hA02);
        check("t5_after_size", 32'(acc_size), 32'd0);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
